// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the memory backend.
package cache_pkg;

  localparam int MEM_ADDR_W = 26;
  localparam int MEM_DATA_W = 128;
  localparam int MEM_TAG_W  = 5;
  localparam int MEM_BEATS  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_backend_sram.sv
// Single-port block storage: one access per cycle, write has priority,
// read data appears one cycle after the read enable.
module mem_backend_sram #(
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int BEATS      = 4,
  localparam int IDX_W     = DEPTH_LOG2 + $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**IDX_W];

  // Storage array with registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end else if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_backend.sv
// Block memory backend: write bursts into a synchronous RAM and stream read
// bursts back through a two-entry prefetch buffer so a held ready sees no bubbles.
module mem_backend
  import cache_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int TAG_W      = MEM_TAG_W,
  parameter int BEATS      = MEM_BEATS,
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_cmd_valid,
  output logic              mem_cmd_ready,
  input  logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic [TAG_W-1:0]  mem_cmd_tag,
  input  logic              mem_cmd_rw,
  input  logic              mem_data_valid,
  output logic              mem_data_ready,
  input  logic [DATA_W-1:0] mem_data_data,
  output logic              mem_resp_valid,
  input  logic              mem_resp_ready,
  output logic [DATA_W-1:0] mem_resp_data,
  output logic [TAG_W-1:0]  mem_resp_tag
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int IDX_W  = DEPTH_LOG2 + BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W:0]   ALL_BEATS = (BEAT_W + 1)'(BEATS);
  localparam logic [3:0]        LAT_INIT  = 4'(READ_LAT - 1);

  mem_state_e              state_r;
  logic [DEPTH_LOG2-1:0]   addr_r;
  logic [BEAT_W-1:0]       wbeat_r;
  logic [BEAT_W:0]         ibeat_r;
  logic [BEAT_W-1:0]       obeat_r;
  logic [3:0]              lat_r;
  logic                    inflight_r;
  logic                    out_v_r;
  logic                    skid_v_r;
  logic [DATA_W-1:0]       skid_data_r;

  logic                    cmd_hs_s;
  logic                    rd_acc_s;
  logic                    wr_acc_s;
  logic                    data_hs_s;
  logic                    pop_s;
  logic                    last_pop_s;
  logic [1:0]              occ_s;
  logic                    issue_s;
  logic [DEPTH_LOG2-1:0]   rd_blk_s;
  logic [IDX_W-1:0]        ram_addr_s;
  logic [DATA_W-1:0]       ram_rdata_s;
  logic                    out_v_nxt_s;
  logic [DATA_W-1:0]       out_d_nxt_s;
  logic                    skid_v_nxt_s;
  logic [DATA_W-1:0]       skid_d_nxt_s;
  logic                    addr_unused_s;

  // Upper address bits alias onto the stored range
  assign addr_unused_s = ^mem_cmd_addr[ADDR_W-1:DEPTH_LOG2];

  assign cmd_hs_s   = mem_cmd_valid & mem_cmd_ready;
  assign rd_acc_s   = cmd_hs_s & ~mem_cmd_rw;
  assign wr_acc_s   = cmd_hs_s & mem_cmd_rw;
  assign data_hs_s  = mem_data_valid & mem_data_ready;
  assign pop_s      = mem_resp_valid & mem_resp_ready;
  assign last_pop_s = pop_s & (obeat_r == LAST_BEAT);
  assign occ_s      = 2'(out_v_r) + 2'(skid_v_r) + 2'(inflight_r);
  assign rd_blk_s   = (state_r == IDLE) ? mem_cmd_addr[DEPTH_LOG2-1:0] : addr_r;
  assign ram_addr_s = data_hs_s ? {addr_r, wbeat_r} : {rd_blk_s, ibeat_r[BEAT_W-1:0]};

  // Read issue: beat 0 goes out on command accept, later beats only when a buffer slot is guaranteed
  always_comb begin
    issue_s = 1'b0;
    if (rd_acc_s) begin
      issue_s = 1'b1;
    end else if ((state_r == RD_WAIT || state_r == RD_RESP) && (ibeat_r < ALL_BEATS) &&
                 ((occ_s < 2'd2) || pop_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Two-entry response buffer: output register is the head, skid register catches RAM data behind it
  always_comb begin
    out_v_nxt_s  = out_v_r;
    out_d_nxt_s  = mem_resp_data;
    skid_v_nxt_s = skid_v_r;
    skid_d_nxt_s = skid_data_r;
    if (pop_s) begin
      if (skid_v_r) begin
        out_d_nxt_s  = skid_data_r;
        skid_v_nxt_s = inflight_r;
        skid_d_nxt_s = inflight_r ? ram_rdata_s : skid_data_r;
      end else if (inflight_r) begin
        out_d_nxt_s = ram_rdata_s;
      end else begin
        out_v_nxt_s = 1'b0;
      end
    end else if (inflight_r) begin
      if (!out_v_r) begin
        out_v_nxt_s = 1'b1;
        out_d_nxt_s = ram_rdata_s;
      end else begin
        skid_v_nxt_s = 1'b1;
        skid_d_nxt_s = ram_rdata_s;
      end
    end else begin
      out_v_nxt_s = out_v_r;
    end
  end

  // Control FSM, counters, response buffers and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      addr_r         <= '0;
      wbeat_r        <= '0;
      ibeat_r        <= '0;
      obeat_r        <= '0;
      lat_r          <= 4'd0;
      inflight_r     <= 1'b0;
      out_v_r        <= 1'b0;
      skid_v_r       <= 1'b0;
      skid_data_r    <= '0;
      mem_cmd_ready  <= 1'b1;
      mem_data_ready <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      mem_resp_tag   <= '0;
    end else begin
      inflight_r    <= issue_s;
      out_v_r       <= out_v_nxt_s;
      mem_resp_data <= out_d_nxt_s;
      skid_v_r      <= skid_v_nxt_s;
      skid_data_r   <= skid_d_nxt_s;
      case (state_r)
        IDLE: begin
          if (wr_acc_s) begin
            addr_r         <= mem_cmd_addr[DEPTH_LOG2-1:0];
            wbeat_r        <= '0;
            state_r        <= WR_DATA;
            mem_cmd_ready  <= 1'b0;
            mem_data_ready <= 1'b1;
          end else if (rd_acc_s) begin
            addr_r        <= mem_cmd_addr[DEPTH_LOG2-1:0];
            mem_resp_tag  <= mem_cmd_tag;
            lat_r         <= LAT_INIT;
            ibeat_r       <= (BEAT_W + 1)'(1);
            obeat_r       <= '0;
            state_r       <= RD_WAIT;
            mem_cmd_ready <= 1'b0;
          end else begin
            mem_cmd_ready  <= 1'b1;
            mem_data_ready <= 1'b0;
            mem_resp_valid <= 1'b0;
          end
        end
        WR_DATA: begin
          if (data_hs_s) begin
            wbeat_r <= wbeat_r + BEAT_W'(1);
            if (wbeat_r == LAST_BEAT) begin
              state_r        <= IDLE;
              mem_data_ready <= 1'b0;
              mem_cmd_ready  <= 1'b1;
            end else begin
              state_r <= WR_DATA;
            end
          end else begin
            state_r <= WR_DATA;
          end
        end
        RD_WAIT: begin
          ibeat_r <= ibeat_r + (BEAT_W + 1)'(issue_s);
          if (lat_r == 4'd0) begin
            state_r        <= RD_RESP;
            mem_resp_valid <= out_v_nxt_s;
          end else begin
            lat_r <= lat_r - 4'd1;
          end
        end
        RD_RESP: begin
          if (last_pop_s) begin
            state_r        <= IDLE;
            ibeat_r        <= '0;
            obeat_r        <= '0;
            mem_resp_valid <= 1'b0;
            mem_cmd_ready  <= 1'b1;
          end else begin
            ibeat_r        <= ibeat_r + (BEAT_W + 1)'(issue_s);
            obeat_r        <= obeat_r + BEAT_W'(pop_s);
            mem_resp_valid <= out_v_nxt_s;
          end
        end
        default: begin
          state_r        <= IDLE;
          mem_cmd_ready  <= 1'b1;
          mem_data_ready <= 1'b0;
          mem_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  mem_backend_sram #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .BEATS     (BEATS)
  ) u_sram (
    .clk  (clk),
    .we   (data_hs_s),
    .re   (issue_s),
    .addr (ram_addr_s),
    .wdata(mem_data_data),
    .rdata(ram_rdata_s)
  );

endmodule

// File: tb/tb_mem_backend.sv
// Directed self-checking bench for mem_backend with default parameters.
module tb_mem_backend;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_cmd_valid = 1'b0;
  logic         mem_cmd_ready;
  logic [25:0]  mem_cmd_addr = 26'h0;
  logic [4:0]   mem_cmd_tag = 5'h0;
  logic         mem_cmd_rw = 1'b0;
  logic         mem_data_valid = 1'b0;
  logic         mem_data_ready;
  logic [127:0] mem_data_data = 128'h0;
  logic         mem_resp_valid;
  logic         mem_resp_ready = 1'b0;
  logic [127:0] mem_resp_data;
  logic [4:0]   mem_resp_tag;

  int n_checks = 0;
  int n_fail = 0;

  logic [127:0] blk_basic [4];
  logic [127:0] blk_a [4];
  logic [127:0] blk_alias [4];
  logic [127:0] blk_c [4];

  always #5 clk = ~clk;

  mem_backend dut (
    .clk           (clk),
    .reset         (reset),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_tag   (mem_cmd_tag),
    .mem_cmd_rw    (mem_cmd_rw),
    .mem_data_valid(mem_data_valid),
    .mem_data_ready(mem_data_ready),
    .mem_data_data (mem_data_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_data (mem_resp_data),
    .mem_resp_tag  (mem_resp_tag)
  );

  // Write a block; called and returns at a negedge. gaps[i] idle cycles precede beat i.
  task automatic wr(input logic [25:0] a, input logic [127:0] b [4], input int gaps [4],
                    input bit early, output int acc_wait, output int beat_wait);
    acc_wait = 0;
    beat_wait = 0;
    if (early) begin
      mem_data_valid = 1'b1;
      mem_data_data = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
    end
    mem_cmd_valid = 1'b1;
    mem_cmd_addr = a;
    mem_cmd_rw = 1'b1;
    while (!mem_cmd_ready && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    @(negedge clk);
    mem_cmd_valid = 1'b0;
    mem_cmd_rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        mem_data_valid = 1'b0;
        @(negedge clk);
      end
      mem_data_valid = 1'b1;
      mem_data_data = b[i];
      while (!mem_data_ready && beat_wait < 20) begin
        @(negedge clk);
        beat_wait++;
      end
      @(negedge clk);
    end
    mem_data_valid = 1'b0;
  endtask

  // Read a block; k counts negedges after the accept edge (k=1 is cycle T+1).
  task automatic rd(input logic [25:0] a, input logic [4:0] t, input bit stall,
                    output logic [127:0] d [4], output logic [4:0] tg [4], output int first_k,
                    output int idx [4], output int nb, output int acc_wait, output bit stable_ok);
    int k;
    int vc;
    bit held;
    logic [127:0] hd;
    logic [4:0] ht;
    nb = 0; first_k = -1; acc_wait = 0; stable_ok = 1'b1;
    held = 1'b0; vc = 0; hd = 128'h0; ht = 5'h0;
    for (int i = 0; i < 4; i++) begin
      d[i] = 128'h0; tg[i] = 5'h0; idx[i] = -1;
    end
    mem_cmd_valid = 1'b1;
    mem_cmd_addr = a;
    mem_cmd_tag = t;
    mem_cmd_rw = 1'b0;
    while (!mem_cmd_ready && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    @(negedge clk);
    mem_cmd_valid = 1'b0;
    k = 1;
    while (nb < 4 && k < 100) begin
      if (held && (!mem_resp_valid || mem_resp_data !== hd || mem_resp_tag !== ht)) stable_ok = 1'b0;
      if (mem_resp_valid) begin
        if (first_k < 0) first_k = k;
        mem_resp_ready = stall ? (vc % 3 == 0) : 1'b1;
        vc++;
        if (mem_resp_ready) begin
          d[nb] = mem_resp_data; tg[nb] = mem_resp_tag; idx[nb] = k;
          nb++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = mem_resp_data; ht = mem_resp_tag;
        end
      end else begin
        mem_resp_ready = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    mem_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", mem_cmd_ready); end
    n_checks++; if (mem_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_data_ready: got %b expected 0", mem_data_ready); end
    n_checks++; if (mem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", mem_resp_valid); end
    n_checks++; if (mem_resp_data !== 128'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h expected 0", mem_resp_data); end
    n_checks++; if (mem_resp_tag !== 5'h0) begin n_fail++; $display("FAIL rst_resp_tag: got %h expected 0", mem_resp_tag); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", mem_cmd_ready); end
  endtask

  task automatic test_basic();
    int g [4]; logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw, bw; bit st;
    g = '{0, 0, 0, 0};
    wr(26'h5, blk_basic, g, 1'b0, aw, bw);
    n_checks++; if (mem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wr_noresp: got %b expected 0", mem_resp_valid); end
    n_checks++; if (mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_wr_done: got %b expected 1", mem_cmd_ready); end
    rd(26'h5, 5'd3, 1'b0, d, tg, fk, idx, nb, aw, st);
    n_checks++; if (fk !== 3) begin n_fail++; $display("FAIL basic_first_lat: got %0d expected 3", fk); end
    n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL basic_nbeats: got %0d expected 4", nb); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_basic[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, d[i], blk_basic[i]); end
      n_checks++; if (tg[i] !== 5'd3) begin n_fail++; $display("FAIL basic_tag[%0d]: got %h expected 3", i, tg[i]); end
      n_checks++; if (idx[i] !== 3 + i) begin n_fail++; $display("FAIL basic_beat_cycle[%0d]: got %0d expected %0d", i, idx[i], 3 + i); end
    end
    n_checks++; if (mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rd_done_ready: got %b expected 1", mem_cmd_ready); end
    n_checks++; if (mem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rd_done_valid: got %b expected 0", mem_resp_valid); end
  endtask

  task automatic test_stall();
    logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw; bit st;
    rd(26'h5, 5'd7, 1'b1, d, tg, fk, idx, nb, aw, st);
    n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL stall_nbeats: got %0d expected 4", nb); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b expected 1", st); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_basic[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, d[i], blk_basic[i]); end
      n_checks++; if (tg[i] !== 5'd7) begin n_fail++; $display("FAIL stall_tag[%0d]: got %h expected 7", i, tg[i]); end
    end
  endtask

  task automatic test_gaps();
    int g [4]; logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw, bw; bit st;
    g = '{1, 3, 0, 2};
    wr(26'h2A, blk_a, g, 1'b1, aw, bw);
    n_checks++; if (bw !== 0) begin n_fail++; $display("FAIL gaps_beat_wait: got %0d expected 0", bw); end
    rd(26'h2A, 5'd9, 1'b0, d, tg, fk, idx, nb, aw, st);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_a[i]) begin n_fail++; $display("FAIL gaps_data[%0d]: got %h expected %h", i, d[i], blk_a[i]); end
    end
  endtask

  task automatic test_alias();
    int g [4]; logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw, bw; bit st;
    g = '{0, 1, 0, 0};
    wr(26'h405, blk_alias, g, 1'b0, aw, bw);
    rd(26'h005, 5'd2, 1'b0, d, tg, fk, idx, nb, aw, st);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_alias[i]) begin n_fail++; $display("FAIL alias_data[%0d]: got %h expected %h", i, d[i], blk_alias[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw, got, k; bit st;
    logic [127:0] seen [2];
    got = 0; k = 0;
    seen[0] = 128'h0; seen[1] = 128'h0;
    mem_cmd_valid = 1'b1; mem_cmd_addr = 26'h5; mem_cmd_tag = 5'd1; mem_cmd_rw = 1'b0;
    mem_resp_ready = 1'b1;
    @(negedge clk);
    mem_cmd_valid = 1'b0;
    while (got < 2 && k < 50) begin
      if (mem_resp_valid) begin
        seen[got] = mem_resp_data;
        got++;
      end
      @(negedge clk);
      k++;
    end
    n_checks++; if (got !== 2) begin n_fail++; $display("FAIL rmid_got: got %0d expected 2", got); end
    n_checks++; if (seen[1] !== blk_alias[1]) begin n_fail++; $display("FAIL rmid_beat1: got %h expected %h", seen[1], blk_alias[1]); end
    n_checks++; if (mem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", mem_resp_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (mem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_drop: got %b expected 0", mem_resp_valid); end
    n_checks++; if (mem_resp_data !== 128'h0) begin n_fail++; $display("FAIL rmid_data_clr: got %h expected 0", mem_resp_data); end
    n_checks++; if (mem_resp_tag !== 5'h0) begin n_fail++; $display("FAIL rmid_tag_clr: got %h expected 0", mem_resp_tag); end
    mem_resp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after: got %b expected 1", mem_cmd_ready); end
    rd(26'h2A, 5'd4, 1'b0, d, tg, fk, idx, nb, aw, st);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_a[i]) begin n_fail++; $display("FAIL rmid_rd_data[%0d]: got %h expected %h", i, d[i], blk_a[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int g [4]; logic [127:0] d [4]; logic [4:0] tg [4]; int idx [4];
    int fk, nb, aw, bw; bit st;
    g = '{0, 0, 0, 0};
    rd(26'h2A, 5'd10, 1'b0, d, tg, fk, idx, nb, aw, st);
    n_checks++; if (d[3] !== blk_a[3]) begin n_fail++; $display("FAIL b2b_rd1_data: got %h expected %h", d[3], blk_a[3]); end
    rd(26'h5, 5'd11, 1'b0, d, tg, fk, idx, nb, aw, st);
    n_checks++; if (aw !== 0) begin n_fail++; $display("FAIL b2b_rd2_accept: got %0d expected 0", aw); end
    n_checks++; if (d[0] !== blk_alias[0]) begin n_fail++; $display("FAIL b2b_rd2_data: got %h expected %h", d[0], blk_alias[0]); end
    n_checks++; if (tg[0] !== 5'd11) begin n_fail++; $display("FAIL b2b_rd2_tag: got %h expected 11", tg[0]); end
    wr(26'h77, blk_c, g, 1'b0, aw, bw);
    n_checks++; if (aw !== 0) begin n_fail++; $display("FAIL b2b_wr_accept: got %0d expected 0", aw); end
    rd(26'h77, 5'd12, 1'b0, d, tg, fk, idx, nb, aw, st);
    n_checks++; if (aw !== 0) begin n_fail++; $display("FAIL b2b_rd3_accept: got %0d expected 0", aw); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (d[i] !== blk_c[i]) begin n_fail++; $display("FAIL b2b_rd3_data[%0d]: got %h expected %h", i, d[i], blk_c[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_basic = '{128'h11, 128'h22, 128'h33, 128'h44};
    blk_a     = '{128'hCAFE_0001_0000_0000_0000_0000_0000_00A1, 128'h8000_0000_0000_0000_0000_0000_0000_00A2,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_00A4};
    blk_alias = '{128'h55, 128'h66, 128'h77, 128'h88};
    blk_c     = '{128'hC1, 128'hC2_0000_0000, 128'hC3_0000_0000_0000_0000, 128'hC4_0000_0000_0000_0000_0000_0000};
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_alias();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
